// File: rtl/seq_det_ctrl_if.sv
// Configuration port of the sequence-detector controller: a ready/valid request
// carrying target pattern, overlap mode and match threshold.
interface seq_det_ctrl_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_threshold;

    modport master (
        output cfg_valid,
        output cfg_pattern,
        output cfg_overlap,
        output cfg_threshold,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_pattern,
        input  cfg_overlap,
        input  cfg_threshold,
        output cfg_ready
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detection controller: sequences IDLE/ARM/RUN/DONE runs
// over a qualified bit stream, counting matches against a run-time configured pattern.
module seq_det_ctrl #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_det_ctrl_if.slave        cfg,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 data_valid,
    input  logic                 data,
    output logic [PAT_W-1:0]     q,
    output logic [1:0]           state,
    output logic                 busy,
    output logic                 match,
    output logic [CNT_W-1:0]     match_count,
    output logic                 done
);

    localparam int unsigned FillW = $clog2(PAT_W + 1);
    localparam logic [FillW-1:0] FillMax = FillW'(PAT_W);
    localparam logic [FillW-1:0] FillArm = FillW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StArm  = 2'b01,
        StRun  = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] q_q, q_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             match_q, match_d;
    logic             done_q, done_d;
    logic [PAT_W-1:0] pattern_q;
    logic             overlap_q;
    logic [CNT_W-1:0] threshold_q;

    logic             cfg_fire;
    logic [PAT_W-1:0] window;
    logic [FillW-1:0] fill_inc;
    logic [CNT_W-1:0] count_inc;

    assign cfg.cfg_ready = (state_q == StIdle) || (state_q == StDone);
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
    assign window        = {q_q[PAT_W-2:0], data};
    assign fill_inc      = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
    assign count_inc     = (count_q == CntMax) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        fill_d  = fill_q;
        count_d = count_q;
        match_d = 1'b0;
        done_d  = done_q;
        unique case (state_q)
            StIdle, StDone: begin
                // stop outranks start; from IDLE it is simply a no-op
                if (stop) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d = StArm;
                    q_d     = '0;
                    fill_d  = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            StArm, StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (data_valid) begin
                    q_d    = window;
                    fill_d = fill_inc;
                    if (state_q == StArm) begin
                        if (fill_inc == FillArm) state_d = StRun;
                    end else if (window == pattern_q) begin
                        match_d = 1'b1;
                        count_d = count_inc;
                        if (threshold_q != '0 && count_inc == threshold_q) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else if (!overlap_q) begin
                            // non-overlapping: next match needs a completely fresh window
                            q_d     = '0;
                            fill_d  = '0;
                            state_d = StArm;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            fill_q  <= '0;
            count_q <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q   <= '0;
            overlap_q   <= 1'b1;
            threshold_q <= '0;
        end else if (cfg_fire) begin
            pattern_q   <= cfg.cfg_pattern;
            overlap_q   <= cfg.cfg_overlap;
            threshold_q <= cfg.cfg_threshold;
        end
    end

    assign q           = q_q;
    assign state       = state_q;
    assign busy        = (state_q == StArm) || (state_q == StRun);
    assign match       = match_q;
    assign match_count = count_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Drives two controllers (8-bit and 2-bit match counters) with shared directed and random
// stimulus and compares every cycle against a history-based reference model.
module tb_seq_det_ctrl;
    localparam int unsigned PAT_W = 4;
    localparam int Mask = (1 << PAT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start, stop, data_valid, data;
    logic             cfg_valid, cfg_overlap;
    logic [PAT_W-1:0] cfg_pattern;
    logic [7:0]       cfg_threshold;

    seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(8)) if_a ();
    seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(2)) if_b ();

    assign if_a.cfg_valid     = cfg_valid;
    assign if_a.cfg_pattern   = cfg_pattern;
    assign if_a.cfg_overlap   = cfg_overlap;
    assign if_a.cfg_threshold = cfg_threshold;
    assign if_b.cfg_valid     = cfg_valid;
    assign if_b.cfg_pattern   = cfg_pattern;
    assign if_b.cfg_overlap   = cfg_overlap;
    assign if_b.cfg_threshold = cfg_threshold[1:0];

    logic [PAT_W-1:0] q_a, q_b;
    logic [1:0]       state_a, state_b;
    logic             busy_a, busy_b, match_a, match_b, done_a, done_b;
    logic [7:0]       cnt_a;
    logic [1:0]       cnt_b;

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg(if_a.slave), .start(start), .stop(stop),
        .data_valid(data_valid), .data(data), .q(q_a), .state(state_a), .busy(busy_a),
        .match(match_a), .match_count(cnt_a), .done(done_a)
    );

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg(if_b.slave), .start(start), .stop(stop),
        .data_valid(data_valid), .data(data), .q(q_b), .state(state_b), .busy(busy_b),
        .match(match_b), .match_count(cnt_b), .done(done_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 active run, 3 done; ARM vs RUN follows from history length.
    int m_mode[2], m_hlen[2], m_hist[2], m_cnt[2], m_pat[2], m_thr[2];
    bit m_ovl[2], m_match[2], m_done[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = 0; m_hlen[m] = 0; m_hist[m] = 0; m_cnt[m] = 0;
            m_pat[m] = 0; m_ovl[m] = 1; m_thr[m] = 0; m_match[m] = 0; m_done[m] = 0;
        end
    endtask

    task automatic model_clear(input int m);
        m_mode[m] = 1; m_hlen[m] = 0; m_hist[m] = 0; m_cnt[m] = 0; m_done[m] = 0;
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int  cmax   = (m == 0) ? 255 : 3;
            int  thr_in = (m == 0) ? int'(cfg_threshold) : int'(cfg_threshold[1:0]);
            bit  rdy    = (m_mode[m] == 0) || (m_mode[m] == 3);
            int  w;
            m_match[m] = 0;
            case (m_mode[m])
                0: if (start && !stop) model_clear(m);
                1: begin
                    if (stop) m_mode[m] = 0;
                    else if (data_valid) begin
                        bit was_run = m_hlen[m] >= int'(PAT_W) - 1;
                        w = ((m_hist[m] << 1) | int'(data)) & Mask;
                        m_hist[m] = w;
                        m_hlen[m] = (m_hlen[m] + 1 > int'(PAT_W)) ? int'(PAT_W) : m_hlen[m] + 1;
                        if (was_run && w == m_pat[m]) begin
                            m_match[m] = 1;
                            if (m_cnt[m] < cmax) m_cnt[m]++;
                            if (m_thr[m] != 0 && m_cnt[m] == m_thr[m]) begin
                                m_mode[m] = 3;
                                m_done[m] = 1;
                            end else if (!m_ovl[m]) begin
                                m_hist[m] = 0;
                                m_hlen[m] = 0;
                            end
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        m_mode[m] = 0;
                        m_done[m] = 0;
                    end else if (start) model_clear(m);
                end
            endcase
            if (rdy && cfg_valid) begin
                m_pat[m] = int'(cfg_pattern);
                m_ovl[m] = cfg_overlap;
                m_thr[m] = thr_in;
            end
        end
    endtask

    function automatic int exp_state(input int m);
        if (m_mode[m] == 0) return 0;
        if (m_mode[m] == 3) return 3;
        return (m_hlen[m] >= int'(PAT_W) - 1) ? 2 : 1;
    endfunction

    task automatic check_dut(input int m, input logic [1:0] st, input logic [PAT_W-1:0] qv,
                             input logic mt, input logic [7:0] cnt, input logic dn,
                             input logic bz, input logic rdy);
        check_eq($sformatf("dut%0d state", m), 32'(st), 32'(exp_state(m)));
        check_eq($sformatf("dut%0d q", m), 32'(qv), 32'(m_hist[m]));
        check_eq($sformatf("dut%0d match", m), 32'(mt), 32'(m_match[m]));
        check_eq($sformatf("dut%0d match_count", m), 32'(cnt), 32'(m_cnt[m]));
        check_eq($sformatf("dut%0d done", m), 32'(dn), 32'(m_done[m]));
        check_eq($sformatf("dut%0d busy", m), 32'(bz), 32'(m_mode[m] == 1));
        check_eq($sformatf("dut%0d cfg_ready", m), 32'(rdy),
                 32'(m_mode[m] == 0 || m_mode[m] == 3));
    endtask

    task automatic check_all();
        check_dut(0, state_a, q_a, match_a, cnt_a, done_a, busy_a, if_a.cfg_ready);
        check_dut(1, state_b, q_b, match_b, {6'd0, cnt_b}, done_b, busy_b, if_b.cfg_ready);
    endtask

    task automatic set_idle();
        start = 0; stop = 0; data_valid = 0; data = 0; cfg_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        set_idle();
    endtask

    task automatic configure(input logic [PAT_W-1:0] p, input logic ovl, input logic [7:0] thr,
                             input logic with_start);
        cfg_valid = 1; cfg_pattern = p; cfg_overlap = ovl; cfg_threshold = thr;
        start = with_start;
        tick();
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
    endtask

    task automatic pulse_stop();
        stop = 1;
        tick();
    endtask

    task automatic send_bit(input logic b);
        data_valid = 1; data = b;
        tick();
    endtask

    bit basic [20] = '{0,1,0,1,1,1,1,0,1,0,0,0,1,1,0,1,0,1,1,0};
    bit ovl_s [7]  = '{1,1,0,1,1,0,1};

    initial begin
        set_idle();
        cfg_pattern = '0; cfg_overlap = 0; cfg_threshold = '0;
        rst_n = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1;

        // Basic detection: two matches, run stays in RUN.
        configure(4'b1011, 1'b1, 8'd0, 1'b0);
        pulse_start();
        foreach (basic[i]) send_bit(basic[i]);
        check_eq("basic count", 32'(cnt_a), 32'd2);
        check_eq("basic state", 32'(state_a), 32'd2);

        // Threshold = 1 ends the run on the first match; cfg with start applies to this run.
        pulse_stop();
        configure(4'b1011, 1'b1, 8'd1, 1'b1);
        foreach (basic[i]) send_bit(basic[i]);
        check_eq("thr state", 32'(state_a), 32'd3);
        check_eq("thr count", 32'(cnt_a), 32'd1);

        // Overlap vs non-overlap on 1101101.
        configure(4'b1101, 1'b1, 8'd0, 1'b1);
        foreach (ovl_s[i]) send_bit(ovl_s[i]);
        check_eq("ovl1 count", 32'(cnt_a), 32'd2);
        pulse_stop();
        configure(4'b1101, 1'b0, 8'd0, 1'b1);
        foreach (ovl_s[i]) send_bit(ovl_s[i]);
        check_eq("ovl0 count", 32'(cnt_a), 32'd1);

        // Gaps inside an occurrence, then saturation of the 2-bit counter.
        pulse_stop();
        configure(4'b1011, 1'b1, 8'd0, 1'b1);
        send_bit(1); tick(); send_bit(0); tick(); tick(); send_bit(1); tick(); send_bit(1);
        check_eq("gap count", 32'(cnt_a), 32'd1);
        for (int k = 0; k < 4; k++) begin
            send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        end
        check_eq("sat count8", 32'(cnt_a), 32'd5);
        check_eq("sat count2", 32'({6'd0, cnt_b}), 32'd3);

        // Stop on the completing bit: no match.
        pulse_stop();
        pulse_start();
        send_bit(1); send_bit(0); send_bit(1);
        stop = 1; data_valid = 1; data = 1;
        tick();
        check_eq("stop match", 32'(match_a), 32'd0);
        check_eq("stop state", 32'(state_a), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom % 12) == 0;
            stop        = ($urandom % 40) == 0;
            data_valid  = ($urandom % 5) != 0;
            data        = 1'($urandom);
            cfg_valid   = ($urandom % 6) == 0;
            cfg_pattern = PAT_W'($urandom);
            cfg_overlap = 1'($urandom);
            cfg_threshold = (($urandom % 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            if (i == 1500) begin
                // Asynchronous reset mid-stream, observed before any clock edge.
                #2;
                rst_n = 0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_n = 1;
            end else begin
                @(posedge clk);
                model_step();
                #1;
                check_all();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
